// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared state/selection types and helpers for the sequential Booth multiplier
package booth_mult_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {NOP, ADD, SUB} booth_sel_t;
  localparam int ABS_W = 64;
  function automatic booth_sel_t decode(input logic q0, input logic qm1);
    return ({q0, qm1} == 2'b01) ? ADD : ({q0, qm1} == 2'b10) ? SUB : NOP;
  endfunction
  // Callers zero-extend into ABS_W bits and keep only their own low bits of the result
  function automatic logic [ABS_W-1:0] abs_2c(input logic [ABS_W-1:0] value, input logic is_neg);
    return is_neg ? ~value + 1'b1 : value;
  endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (add/sub then arithmetic right shift of {A,Q,Qm1})
module booth_step
  import booth_mult_pkg::*;
#(
  parameter int W1 = 17
) (
  input  logic [W1-1:0] a,
  input  logic [W1-1:0] q,
  input  logic          qm1,
  input  logic [W1-1:0] m,
  input  logic [W1-1:0] neg_m,
  output logic [W1-1:0] a_next,
  output logic [W1-1:0] q_next,
  output logic          qm1_next
);
  booth_sel_t sel;
  logic [W1-1:0] sum;
  always_comb begin
    sel = decode(q[0], qm1);
    sum = (sel == ADD) ? a + m : (sel == SUB) ? a + neg_m : a;
    {a_next, q_next, qm1_next} = {sum[W1-1], sum, q};
  end
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: start/done handshaked sequential radix-2 Booth multiplier with magnitude/sign output
module booth_mult_seq
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   product_mag,
  output logic                 product_neg
);
  localparam int W1 = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 2);
  state_t state, state_next;
  logic [W1-1:0] a, q, m, neg_m, a_next, q_next, q_ext, m_ext;
  logic qm1, qm1_next, mode, last, neg_next;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] prod_next;
  booth_step #(.W1(W1)) u_step (
    .a(a), .q(q), .qm1(qm1), .m(m), .neg_m(neg_m),
    .a_next(a_next), .q_next(q_next), .qm1_next(qm1_next)
  );
  always_comb begin
    q_ext = {signed_mode & multiplier[WIDTH-1], multiplier};
    m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    last = cnt == CNT_W'(W1 - 1);
    prod_next = {a_next[WIDTH-2:0], q_next};
    neg_next = mode & prod_next[2*WIDTH-1];
    state_next = (state == IDLE) ? (start ? BUSY : IDLE) :
                 (state == BUSY) ? (last ? DONE : BUSY) : IDLE;
  end
  assign ready = state == IDLE;
  assign busy = state == BUSY;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {a, q, qm1, m, neg_m, cnt, mode} <= '0;
      {product, product_mag, product_neg} <= '0;
    end else if (state == IDLE && start) begin
      a <= '0;
      q <= q_ext;
      qm1 <= 1'b0;
      m <= m_ext;
      neg_m <= -m_ext;
      cnt <= '0;
      mode <= signed_mode;
    end else if (state == BUSY) begin
      a <= a_next;
      q <= q_next;
      qm1 <= qm1_next;
      cnt <= cnt + 1'b1;
      // The final step's result goes straight to the product registers
      if (last) begin
        product <= prod_next;
        product_mag <= (2*WIDTH)'(abs_2c(ABS_W'(prod_next), neg_next));
        product_neg <= neg_next;
      end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed table + corner sequences on WIDTH=16, random model checks on 4/8/16/32
module tb_booth_mult_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: extend each operand per mode, multiply as integers, keep 2w bits
  function automatic logic [63:0] ref_prod(input int w, input logic s, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mk, m2, xe, ye, p;
    mk = (64'd1 << w) - 1;
    m2 = (w == 32) ? '1 : (64'd1 << (2 * w)) - 1;
    xe = x & mk;
    ye = y & mk;
    if (s && xe[w-1]) xe = xe | ~mk;
    if (s && ye[w-1]) ye = ye | ~mk;
    p = xe * ye;
    return p & m2;
  endfunction

  function automatic logic ref_neg(input int w, input logic s, input logic [63:0] p);
    return s && p[2*w-1];
  endfunction

  function automatic logic [63:0] ref_mag(input int w, input logic s, input logic [63:0] p);
    logic [63:0] m2;
    m2 = (w == 32) ? '1 : (64'd1 << (2 * w)) - 1;
    return ref_neg(w, s, p) ? (-p) & m2 : p;
  endfunction

  logic rst_n, start, sm;
  logic [15:0] mq, mm;
  logic rdy, bsy, dn, neg;
  logic [31:0] prod, mag;
  booth_mult_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(rst_n), .start(start), .signed_mode(sm),
    .multiplier(mq), .multiplicand(mm),
    .ready(rdy), .busy(bsy), .done(dn),
    .product(prod), .product_mag(mag), .product_neg(neg)
  );

  always @(negedge clk) chk("onehot16", 64'($countones({rdy, bsy, dn})), 64'd1);

  for (genvar g = 0; g < 4; g++) begin : gw
    localparam int W = 4 << g;
    logic r_n, st, s_m, rd, bs, d, pn, fin;
    logic [W-1:0] q, m;
    logic [2*W-1:0] p, pm;
    booth_mult_seq #(.WIDTH(W)) u (
      .clk(clk), .reset(r_n), .start(st), .signed_mode(s_m),
      .multiplier(q), .multiplicand(m),
      .ready(rd), .busy(bs), .done(d),
      .product(p), .product_mag(pm), .product_neg(pn)
    );
    always @(negedge clk) chk($sformatf("onehot_w%0d", W), 64'($countones({rd, bs, d})), 64'd1);

    function automatic logic [W-1:0] pick;
      int k;
      k = $urandom_range(0, 7);
      return (k == 0) ? '0 : (k == 1) ? '1 : (k == 2) ? {1'b1, {(W-1){1'b0}}} :
             (k == 3) ? {1'b0, {(W-1){1'b1}}} : W'($urandom);
    endfunction

    initial begin
      logic [63:0] ep;
      int t;
      fin = 1'b0;
      r_n = 1'b0;
      st = 1'b0;
      s_m = 1'b0;
      q = '0;
      m = '0;
      tick();
      r_n = 1'b1;
      tick();
      for (int i = 0; i < 400; i++) begin
        q = pick();
        m = pick();
        s_m = 1'($urandom);
        st = 1'b1;
        tick();
        st = 1'b0;
        q = W'($urandom);
        m = W'($urandom);
        t = 0;
        while (!d && t < 60) begin
          tick();
          t++;
        end
        chk($sformatf("lat_w%0d", W), 64'(t), 64'(W + 1));
        ep = ref_prod(W, u.mode, 64'(u.q), 64'(u.m));
        tick();
      end
      fin = 1'b1;
    end
  end

  // Random checks are sampled at the done cycle against operands captured at issue
  for (genvar g = 0; g < 4; g++) begin : gc
    localparam int W = 4 << g;
    logic [W-1:0] cq, cm;
    logic cs;
    always @(posedge clk) if (gw[g].st && gw[g].rd) begin
      cq <= gw[g].q;
      cm <= gw[g].m;
      cs <= gw[g].s_m;
    end
    always @(negedge clk) if (gw[g].d) begin
      logic [63:0] e;
      e = ref_prod(W, cs, 64'(cq), 64'(cm));
      chk($sformatf("prod_w%0d", W), 64'(gw[g].p), e);
      chk($sformatf("mag_w%0d", W), 64'(gw[g].pm), ref_mag(W, cs, e));
      chk($sformatf("neg_w%0d", W), 64'(gw[g].pn), 64'(ref_neg(W, cs, e)));
    end
  end

  typedef struct {
    logic s;
    logic [15:0] q, m;
    logic [31:0] p, pm;
    logic pn;
  } vec_t;

  task automatic run16(input logic s, input logic [15:0] q, input logic [15:0] m, output int lat);
    sm = s;
    mq = q;
    mm = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    mq = 16'hA5A5;
    mm = 16'h5A5A;
    sm = ~s;
    lat = 0;
    while (!dn && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    vec_t tv[8];
    int lat, nd, last_d;
    tv[0] = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, 32'h00000015, 1'b1};
    tv[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'hFFFE0001, 1'b0};
    tv[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 32'h00000001, 1'b0};
    tv[3] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 32'h40000000, 1'b0};
    tv[4] = '{1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 32'h3FFF8000, 1'b1};
    tv[5] = '{1'b1, 16'h0000, 16'h8000, 32'h00000000, 32'h00000000, 1'b0};
    tv[6] = '{1'b0, 16'h8000, 16'h8000, 32'h40000000, 32'h40000000, 1'b0};
    tv[7] = '{1'b1, 16'h0005, 16'hFFFA, 32'hFFFFFFE2, 32'h0000001E, 1'b1};
    rst_n = 1'b0;
    start = 1'b0;
    sm = 1'b0;
    mq = '0;
    mm = '0;
    #3;
    chk("rst_ready", 64'(rdy), 64'd1);
    chk("rst_busy", 64'(bsy), 64'd0);
    chk("rst_done", 64'(dn), 64'd0);
    chk("rst_prod", 64'(prod), 64'd0);
    chk("rst_mag", 64'(mag), 64'd0);
    chk("rst_neg", 64'(neg), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    foreach (tv[i]) begin
      run16(tv[i].s, tv[i].q, tv[i].m, lat);
      chk($sformatf("lat[%0d]", i), 64'(lat), 64'd17);
      chk($sformatf("prod[%0d]", i), 64'(prod), 64'(tv[i].p));
      chk($sformatf("mag[%0d]", i), 64'(mag), 64'(tv[i].pm));
      chk($sformatf("neg[%0d]", i), 64'(neg), 64'(tv[i].pn));
      tick();
    end
    // Start held high: one done every WIDTH+3 cycles
    sm = 1'b0;
    mq = 16'd3;
    mm = 16'd4;
    start = 1'b1;
    nd = 0;
    last_d = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (dn) begin
        if (last_d >= 0) chk("held_period", 64'(c - last_d), 64'd19);
        last_d = c;
        nd++;
        chk("held_prod", 64'(prod), 64'd12);
      end
    end
    chk("held_count", 64'(nd), 64'd3);
    start = 1'b0;
    while (!rdy) tick();
    // Start pulsed during BUSY must not re-sample or queue an operation
    sm = 1'b0;
    mq = 16'd2;
    mm = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    mq = 16'd9;
    mm = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int c = 0; c < 45; c++) begin
      if (dn) begin
        nd++;
        chk("busy_start_prod", 64'(prod), 64'd6);
      end
      tick();
    end
    chk("busy_start_count", 64'(nd), 64'd1);
    // Asynchronous abort mid-operation
    sm = 1'b1;
    mq = 16'd7;
    mm = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("abort_busy_before", 64'(bsy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(rdy), 64'd1);
    chk("abort_prod", 64'(prod), 64'd0);
    chk("abort_mag", 64'(mag), 64'd0);
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      if (dn) nd++;
      tick();
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run16(1'b1, 16'd5, 16'd6, lat);
    chk("after_abort_lat", 64'(lat), 64'd17);
    chk("after_abort_prod", 64'(prod), 64'h1E);
    tick();
    lat = 0;
    while (!(gw[0].fin && gw[1].fin && gw[2].fin && gw[3].fin) && lat < 60000) begin
      tick();
      lat++;
    end
    chk("random_complete", 64'(gw[0].fin && gw[1].fin && gw[2].fin && gw[3].fin), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
